// File: rtl/rtg_pkg.sv
// Shared definitions for the reaction-time game controller and its datapath.
package rtg_pkg;

  localparam int unsigned SCORE_W   = 13;
  localparam logic [12:0] SCORE_SAT = 13'h1FFF;
  localparam logic [7:0]  LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 : taps on bits 7,5,4,3 of a left-shifting register
  localparam logic [7:0]  LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    WAIT,
    GO,
    PENALTY,
    REC_SCORE,
    REC_COUNT,
    DONE
  } state_t;

endpackage

// File: rtl/reaction_round_controller_if.sv
// Controller-to-datapath bundle: ms strobe, buttons, lamps, register file port.
interface reaction_round_controller_if #(
  parameter int SCORE_W = rtg_pkg::SCORE_W
);

  logic               msTick;
  logic               buttonStart;
  logic               buttonHit;
  logic               buttonReset;
  logic               GreenLed;
  logic               RedLed;
  logic [2:0]         WriteAddress;
  logic               registerLoad;
  logic [SCORE_W-1:0] registerLoadData;
  logic [2:0]         ReadQ;
  logic               busy;

  modport master (
    input  msTick, buttonStart, buttonHit, buttonReset,
    output GreenLed, RedLed, WriteAddress, registerLoad, registerLoadData, ReadQ, busy
  );

  modport slave (
    output msTick, buttonStart, buttonHit, buttonReset,
    input  GreenLed, RedLed, WriteAddress, registerLoad, registerLoadData, ReadQ, busy
  );

endinterface

// File: rtl/rtg_edge_detect.sv
// Registered rising-edge detector for one synchronized button level.
module rtg_edge_detect (
  input  logic Clock,
  input  logic Reset,
  input  logic level,
  output logic rise
);

  logic prev;

  // Remember last cycle's level so each press yields a single event
  always_ff @(posedge Clock) begin
    if (Reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/reaction_round_controller.sv
// Round sequencer: clears the register file, runs random delay, times the
// reaction, applies penalties and records scores plus the round count.
module reaction_round_controller #(
  parameter int SCORE_W    = 13,
  parameter int LFSR_W     = 8,
  parameter int DELAY_MIN  = 1000,
  parameter int PENALTY_MS = 500,
  parameter int MAX_ROUNDS = 4
) (
  input logic Clock,
  input logic Reset,
  reaction_round_controller_if.master bus
);

  import rtg_pkg::*;

  localparam int DELAY_W = $clog2(DELAY_MIN + (4 << LFSR_W)) + 1;
  localparam int PEN_W   = $clog2(PENALTY_MS + 1);
  localparam logic [SCORE_W-1:0] SAT      = '1;
  localparam logic [2:0]         LAST_IDX = 3'(MAX_ROUNDS);

  state_t             state;
  logic [2:0]         clrIdx;
  logic [2:0]         round;
  logic [2:0]         readQ;
  logic [LFSR_W-1:0]  lfsr;
  logic [DELAY_W-1:0] delay;
  logic [PEN_W-1:0]   penCnt;
  logic [SCORE_W-1:0] score;
  logic               startEv;
  logic               hitEv;
  logic               resetEv;

  rtg_edge_detect startEdge (.Clock(Clock), .Reset(Reset), .level(bus.buttonStart), .rise(startEv));
  rtg_edge_detect hitEdge   (.Clock(Clock), .Reset(Reset), .level(bus.buttonHit),   .rise(hitEv));
  rtg_edge_detect resetEdge (.Clock(Clock), .Reset(Reset), .level(bus.buttonReset), .rise(resetEv));

  // Free-running Fibonacci LFSR supplying the random part of the delay
  always_ff @(posedge Clock) begin
    if (Reset) lfsr <= LFSR_W'(LFSR_SEED);
    else       lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_W'(LFSR_TAPS))};
  end

  // Round sequencing; a reset-button event overrides everything but CLEAR
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= CLEAR;
      clrIdx <= '0;
      round  <= '0;
      readQ  <= 3'd1;
      delay  <= '0;
      penCnt <= '0;
      score  <= '0;
    end else if (resetEv && (state != CLEAR)) begin
      state  <= CLEAR;
      clrIdx <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (clrIdx == LAST_IDX) begin
            clrIdx <= '0;
            round  <= '0;
            state  <= IDLE;
          end else begin
            clrIdx <= clrIdx + 3'd1;
          end
        end
        IDLE: begin
          if (startEv) begin
            delay <= DELAY_W'(DELAY_MIN) + DELAY_W'({lfsr, 2'b00});
            state <= WAIT;
          end
        end
        WAIT: begin
          // Hit is tested before the tick so a same-cycle hit counts as early
          if (hitEv) begin
            score  <= SAT;
            penCnt <= PEN_W'(PENALTY_MS);
            state  <= PENALTY;
          end else if (bus.msTick) begin
            delay <= delay - DELAY_W'(1);
            if (delay == DELAY_W'(1)) begin
              score <= '0;
              state <= GO;
            end
          end
        end
        GO: begin
          // Hit first: a same-cycle tick must not bump the recorded score
          if (hitEv) begin
            state <= REC_SCORE;
          end else if (bus.msTick) begin
            score <= score + SCORE_W'(1);
            if (score == SAT - SCORE_W'(1)) begin
              penCnt <= PEN_W'(PENALTY_MS);
              state  <= PENALTY;
            end
          end
        end
        PENALTY: begin
          if (bus.msTick) begin
            if (penCnt == PEN_W'(1)) state <= REC_SCORE;
            else                     penCnt <= penCnt - PEN_W'(1);
          end
        end
        REC_SCORE: begin
          readQ <= round + 3'd1;
          state <= REC_COUNT;
        end
        REC_COUNT: begin
          round <= round + 3'd1;
          state <= ((round + 3'd1) == LAST_IDX) ? DONE : IDLE;
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

  // Register file write port; held quiet while Reset is asserted
  always_comb begin
    bus.registerLoad     = 1'b0;
    bus.WriteAddress     = '0;
    bus.registerLoadData = '0;
    if (!Reset) begin
      case (state)
        CLEAR: begin
          bus.registerLoad = 1'b1;
          bus.WriteAddress = clrIdx;
        end
        REC_SCORE: begin
          bus.registerLoad     = 1'b1;
          bus.WriteAddress     = round + 3'd1;
          bus.registerLoadData = score;
        end
        REC_COUNT: begin
          bus.registerLoad     = 1'b1;
          bus.WriteAddress     = '0;
          bus.registerLoadData = SCORE_W'(round + 3'd1);
        end
        default: begin
          bus.registerLoad = 1'b0;
        end
      endcase
    end
  end

  assign bus.GreenLed = (state == GO);
  assign bus.RedLed   = (state == PENALTY);
  assign bus.busy     = !Reset && (state != IDLE) && (state != DONE);
  assign bus.ReadQ    = readQ;

endmodule

// File: tb/tb_reaction_round_controller.sv
// Directed bench for reaction_round_controller with a register-file shadow.
module tb_reaction_round_controller;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  reaction_round_controller_if #(.SCORE_W(13)) bus ();

  reaction_round_controller #(
    .SCORE_W(13),
    .LFSR_W(8),
    .DELAY_MIN(1000),
    .PENALTY_MS(500),
    .MAX_ROUNDS(4)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 Clock = ~Clock;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned writeCount = 0;
  logic [12:0] regs [0:7];
  logic [7:0]  refLfsr;
  logic        greenSeen = 1'b0;

  // Independent model of x^8+x^6+x^5+x^4+1, seeded 8'hA5
  always @(posedge Clock) begin
    if (Reset) refLfsr <= 8'hA5;
    else       refLfsr <= {refLfsr[6:0], refLfsr[7] ^ refLfsr[5] ^ refLfsr[4] ^ refLfsr[3]};
  end

  // Shadow register file and lamp monitor, sampled mid-cycle
  always @(negedge Clock) begin
    if (bus.registerLoad === 1'b1) begin
      regs[bus.WriteAddress] = bus.registerLoadData;
      writeCount++;
    end
    if (bus.GreenLed === 1'b1) greenSeen = 1'b1;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic tick, input logic st, input logic hit, input logic rst);
    bus.msTick      = tick;
    bus.buttonStart = st;
    bus.buttonHit   = hit;
    bus.buttonReset = rst;
    @(posedge Clock);
    #1;
  endtask

  task automatic tick();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkClear(input string tag);
    int unsigned w0;
    w0 = writeCount;
    checkValue({tag, " busy"}, bus.busy, 1);
    for (int unsigned k = 0; k <= 4; k++) begin
      checkValue({tag, " clr load"}, bus.registerLoad, 1);
      checkValue({tag, " clr addr"}, bus.WriteAddress, k);
      checkValue({tag, " clr data"}, bus.registerLoadData, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    checkValue({tag, " write count"}, writeCount - w0, 5);
    checkValue({tag, " idle busy"}, bus.busy, 0);
    checkValue({tag, " idle load"}, bus.registerLoad, 0);
    checkValue({tag, " idle green"}, bus.GreenLed, 0);
    checkValue({tag, " idle red"}, bus.RedLed, 0);
    for (int unsigned k = 0; k <= 4; k++) checkValue({tag, " reg zero"}, regs[k], 0);
  endtask

  task automatic pressStart(output int unsigned d);
    d = 1000 + 4 * int'(refLfsr);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic waitGo(input int unsigned d);
    for (int unsigned i = 1; i < d; i++) tick();
    checkValue("green before last delay tick", bus.GreenLed, 0);
    tick();
    checkValue("green after delay", bus.GreenLed, 1);
  endtask

  task automatic recordCheck(input logic [2:0] slot, input logic [12:0] score);
    checkValue("recScore load", bus.registerLoad, 1);
    checkValue("recScore addr", bus.WriteAddress, slot);
    checkValue("recScore data", bus.registerLoadData, score);
    checkValue("recScore green", bus.GreenLed, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("recCount load", bus.registerLoad, 1);
    checkValue("recCount addr", bus.WriteAddress, 0);
    checkValue("recCount data", bus.registerLoadData, slot);
    checkValue("readQ", bus.ReadQ, slot);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("post record load", bus.registerLoad, 0);
  endtask

  task automatic penaltyPhase();
    for (int unsigned i = 1; i < 500; i++) tick();
    checkValue("red before last penalty tick", bus.RedLed, 1);
    checkValue("no write in penalty", bus.registerLoad, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    checkValue("red after penalty", bus.RedLed, 0);
  endtask

  task automatic goodRound(input logic [2:0] slot, input int unsigned n, input logic tickWithHit);
    int unsigned d;
    pressStart(d);
    waitGo(d);
    for (int unsigned i = 0; i < n; i++) tick();
    cyc(tickWithHit, 1'b0, 1'b1, 1'b0);
    recordCheck(slot, 13'(n));
  endtask

  initial begin
    int unsigned d;
    int unsigned w;
    int unsigned exp1 [5] = '{4, 237, 8191, 8191, 50};
    int unsigned exp2 [5] = '{4, 5, 300, 0, 1};

    for (int i = 0; i < 8; i++) regs[i] = 13'h1555;

    // Power-on reset held two cycles
    Reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("reset load", bus.registerLoad, 0);
    checkValue("reset addr", bus.WriteAddress, 0);
    checkValue("reset data", bus.registerLoadData, 0);
    checkValue("reset green", bus.GreenLed, 0);
    checkValue("reset red", bus.RedLed, 0);
    checkValue("reset busy", bus.busy, 0);
    checkValue("reset readQ", bus.ReadQ, 1);
    Reset = 1'b0;
    #1;
    checkClear("por");

    // Game 1, round 1: latch with lfsr at its seed value
    for (int i = 0; i < 300 && refLfsr != 8'hA5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("lfsr seed reachable", refLfsr, 8'hA5);
    goodRound(3'd1, 237, 1'b0);

    // Round 2: early hit in WAIT
    greenSeen = 1'b0;
    pressStart(d);
    for (int i = 0; i < 10; i++) tick();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    checkValue("early hit red", bus.RedLed, 1);
    penaltyPhase();
    recordCheck(3'd2, 13'h1FFF);
    checkValue("early round never green", greenSeen, 0);

    // Round 3: no hit, score saturates
    pressStart(d);
    waitGo(d);
    for (int unsigned i = 0; i < 8190; i++) tick();
    checkValue("green before saturation", bus.GreenLed, 1);
    checkValue("red before saturation", bus.RedLed, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    checkValue("green after timeout", bus.GreenLed, 0);
    checkValue("red after timeout", bus.RedLed, 1);
    penaltyPhase();
    recordCheck(3'd3, 13'h1FFF);

    // Round 4: hit coincident with a tick keeps the pre-increment score
    goodRound(3'd4, 50, 1'b1);
    checkValue("done busy", bus.busy, 0);
    for (int unsigned k = 0; k <= 4; k++) checkValue("game1 reg", regs[k], exp1[k]);

    // Start is ignored once the game is done
    w = writeCount;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    checkValue("done start writes", writeCount - w, 0);
    checkValue("done start busy", bus.busy, 0);
    checkValue("done start green", bus.GreenLed, 0);

    // Game 2: four good rounds after a button reset
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    checkClear("reset from done");
    goodRound(3'd1, 5, 1'b1);
    goodRound(3'd2, 300, 1'b0);
    goodRound(3'd3, 0, 1'b0);
    goodRound(3'd4, 1, 1'b1);
    checkValue("game2 done busy", bus.busy, 0);
    for (int unsigned k = 0; k <= 4; k++) checkValue("game2 reg", regs[k], exp2[k]);

    // Game 3: hit on the final delay tick is early; then reset from PENALTY
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    checkClear("reset game3");
    greenSeen = 1'b0;
    pressStart(d);
    for (int unsigned i = 1; i < d; i++) tick();
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    checkValue("hit on last tick red", bus.RedLed, 1);
    checkValue("hit on last tick green", bus.GreenLed, 0);
    checkValue("hit on last tick never green", greenSeen, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    checkValue("reset in penalty red", bus.RedLed, 0);
    checkClear("reset in penalty");

    // Reset together with a hit during GO aborts without a score write
    pressStart(d);
    waitGo(d);
    for (int i = 0; i < 20; i++) tick();
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    checkValue("reset in go green", bus.GreenLed, 0);
    checkClear("reset in go");
    goodRound(3'd1, 7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reaction_round_controller.md
Name: reaction_round_controller

Overview:
- Sequencing controller for the reaction-time game datapath.
- Owns the 8x13-bit register file write port and the display read select.
- Generates a pseudo-random pre-stimulus delay, times the player's reaction in millisecond ticks, and handles early hits and timeouts.
- Records up to MAX_ROUNDS scores into register slots 1..MAX_ROUNDS and keeps the completed-round count in register 0.

Parameters:
- SCORE_W, 13: score and register data width.
- LFSR_W, 8: width of the delay LFSR.
- DELAY_MIN, 1000: minimum pre-stimulus delay in ms ticks.
- PENALTY_MS, 500: RedLed hold time after an early hit or timeout, in ms ticks.
- MAX_ROUNDS, 4: rounds per game; must be 1..7.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- msTick  in  1  one-cycle strobe per millisecond, from the divide-by-50000 counter.
- buttonStart  in  1  synchronized level; rising edge starts a round.
- buttonHit  in  1  synchronized level; rising edge is the player hit.
- buttonReset  in  1  synchronized level; rising edge clears the game.
- GreenLed  out  1  stimulus lamp.
- RedLed  out  1  penalty/timeout lamp.
- WriteAddress  out  3  register file WA.
- registerLoad  out  1  register file WR, one-cycle pulse.
- registerLoadData  out  SCORE_W  register file LD_DATA.
- ReadQ  out  3  register file RQ; selects the slot shown on Screen1-4.
- busy  out  1  high in any state other than IDLE and DONE.

Behaviour:
- Reset values: state=CLEAR, clrIdx=0, round=0, lfsr=8'hA5, all outputs 0, ReadQ=3'd1.
- Edge detect: each button is registered once; an event is level & ~prev. Events are evaluated only in the states listed below and are ignored elsewhere.
- LFSR: advances every Clock. Polynomial x^8+x^6+x^5+x^4+1, Fibonacci form, shifts left, feedback into bit 0. The all-zero state is unreachable from the seed.
- CLEAR: writes 0 to addresses 0..MAX_ROUNDS, one per cycle, with registerLoad high each cycle. Then sets round=0 and goes to IDLE.
- IDLE: a start event latches delay = DELAY_MIN + {lfsr,2'b00} (0..1020 extra ms) and moves to WAIT.
- WAIT: decrements delay on each msTick.
  - When delay reaches 0: go to GO, set GreenLed=1, score=0.
  - A hit event before that point goes to PENALTY with score=13'h1FFF.
  - If a hit event and the final tick fall in the same cycle, the hit wins (early).
- GO: increments score on each msTick, saturating at 13'h1FFF.
  - A hit event goes to REC_SCORE with score as-is; a hit in the same cycle as a tick records the pre-increment value.
  - Reaching 13'h1FFF goes to PENALTY (timeout).
  - GreenLed drops when GO is left.
- PENALTY: RedLed=1 for PENALTY_MS ticks, then REC_SCORE. RedLed=0 on exit.
- REC_SCORE: single cycle.
  - WA=round+1, LD_DATA=score, registerLoad=1, ReadQ<=round+1.
  - Latency from the hit-event cycle to the write pulse is exactly 1 cycle.
- REC_COUNT: single cycle. WA=0, LD_DATA=round+1 (zero-extended), registerLoad=1, round<=round+1.
  - If round+1==MAX_ROUNDS go to DONE, else IDLE.
- DONE: start events ignored; registers retain data.
- buttonReset event:
  - Honoured in every state except CLEAR; goes to CLEAR on the next cycle.
  - Aborts any round in progress; no partial score is written.
  - GreenLed and RedLed drop on the transition.
  - Takes priority over a simultaneous hit or start event.
- Reset mid-operation returns all state to the reset values, and CLEAR re-zeroes the file.
- registerLoad is never high for two different addresses in the same cycle. Outside CLEAR, REC_SCORE and REC_COUNT it is 0.

Decomposition:
- Shared package rtg_pkg holds:
  - state enum (CLEAR, IDLE, WAIT, GO, PENALTY, REC_SCORE, REC_COUNT, DONE);
  - SCORE_W;
  - SCORE_SAT=13'h1FFF;
  - LFSR_SEED=8'hA5;
  - the LFSR tap mask.
- One natural sub-module, rtg_edge_detect (per-button registered rising-edge), instanced three times.
- The LFSR stays inline.

Test Plan:
- Reset held 2 cycles, then released -> 5 consecutive writes of 0 to WA 0..4, then IDLE with busy=0 and all LEDs 0.
- Start, lfsr=8'hA5 at latch -> GreenLed rises after exactly 1000+660 msTicks. Hit after 237 ticks -> WA=1, LD_DATA=237 one cycle later; next cycle WA=0, LD_DATA=1; ReadQ=1.
- Hit during WAIT -> RedLed high for 500 ticks, then WA=1 gets 8191, WA=0 gets 1, GreenLed never asserted.
- No hit in GO -> score saturates at 8191, RedLed 500 ticks, 8191 recorded.
- Four good rounds -> slots 1..4 hold the scores, reg0=4, DONE; a fifth start produces no write.
- buttonReset during GO -> LEDs drop next cycle, no score write, CLEAR sequence rewrites 0..4 to 0, round=0.
